// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - loadable instruction memory with registered one-cycle fetch port
// Clears itself to NOP_WORD after reset, then serves fetches or accepts a streamed program load.
module imem_loadable #(
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 64,
    parameter int                 ADDR_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_fault,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        READY = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              fetch_acc;
    logic              fetch_bad;
    logic [IDX_W-1:0]  fetch_idx;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    // fetch_ready is a registered copy of (state == READY), so it gates acceptance directly
    assign fetch_acc = fetch_ready && fetch_req;
    assign fetch_idx = fetch_addr[IDX_W+1:2];
    assign fetch_bad = (|fetch_addr[1:0]) || (|(fetch_addr >> (IDX_W + 2)));

    // Clear and load share the single write port and the one pointer
    assign mem_we    = (state == CLEAR) || ((state == LOAD) && load_valid);
    assign mem_wdata = (state == LOAD) ? load_data : NOP_WORD;

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[ptr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR;
            ptr         <= '0;
            fetch_ready <= 1'b0;
            load_ready  <= 1'b0;
            load_done   <= 1'b0;
            instr_valid <= 1'b0;
            instr_fault <= 1'b0;
            instruction <= NOP_WORD;
        end else begin
            load_done   <= 1'b0;
            instr_valid <= fetch_acc;
            if (fetch_acc) begin
                instr_fault <= fetch_bad;
                instruction <= fetch_bad ? NOP_WORD : mem[fetch_idx];
            end
            case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_IDX) begin
                        state       <= READY;
                        fetch_ready <= 1'b1;
                    end
                end
                READY: begin
                    if (load_start) begin
                        state       <= LOAD;
                        ptr         <= '0;
                        fetch_ready <= 1'b0;
                        load_ready  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        ptr <= ptr + 1'b1;
                        if (load_last || (ptr == LAST_IDX)) begin
                            state       <= READY;
                            load_ready  <= 1'b0;
                            fetch_ready <= 1'b1;
                            load_done   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= CLEAR;
                    ptr         <= '0;
                    fetch_ready <= 1'b0;
                    load_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loadable.sv
// tb/tb_imem_loadable.sv - scoreboard bench for imem_loadable
module tb_imem_loadable;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        instr_fault;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;

    imem_loadable dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .instr_valid(instr_valid),
        .instruction(instruction),
        .instr_fault(instr_fault),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model [64];
    logic [32:0] sb [$];
    logic [31:0] ldq [$];
    bit          in_load = 0;
    int          bptr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] expect_of(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a[31:2] >= 30'd64) return {1'b1, 32'h0};
        return {1'b0, model[a[7:2]]};
    endfunction

    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst && instr_valid) begin
            if (sb.size() == 0) begin
                check("spurious_resp", 1, 0);
            end else begin
                e = sb.pop_front();
                check("instruction", instruction, e[31:0]);
                check("instr_fault", instr_fault, e[32]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        if (fetch_ready) sb.push_back(expect_of(a));
        step();
    endtask

    task automatic idle(input int n);
        fetch_req  = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        repeat (n) step();
    endtask

    task automatic chk_reset_outs(input string tag);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_fault"}, instr_fault, 0);
        check({tag, "_instr"}, instruction, 0);
        check({tag, "_done"}, load_done, 0);
        check({tag, "_fready"}, fetch_ready, 0);
        check({tag, "_lready"}, load_ready, 0);
    endtask

    task automatic wait_clear(input string tag);
        int cycles = 0;
        while (!fetch_ready && cycles < 200) begin
            step();
            cycles++;
        end
        check(tag, cycles, 64);
        foreach (model[i]) model[i] = 32'h0;
    endtask

    // Streams ldq; the bench tracks its own pointer to know which words land and when done fires
    task automatic load_words(input bit do_start, input int n, input bit with_last);
        bit fin;
        if (do_start) begin
            load_start = 1'b1;
            step();
            load_start = 1'b0;
        end
        check("load_ready", load_ready, 1);
        in_load = 1;
        bptr = 0;
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = ldq[i];
            load_last  = with_last && (i == n - 1);
            fin = 0;
            if (in_load) begin
                model[bptr] = ldq[i];
                fin = load_last || (bptr == 63);
                bptr++;
            end
            step();
            check("load_done", load_done, fin);
            if (fin) in_load = 0;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fetch_req = 0; fetch_addr = 0;
        load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
        repeat (3) step();
        chk_reset_outs("rst_hold");
        rst = 1'b0;
        check("clear_fready", fetch_ready, 0);
        wait_clear("clear_cycles");

        fetch(32'h0);
        idle(2);

        ldq = '{32'h20080020, 32'h20090037, 32'h01098024};
        load_words(1, 3, 1);
        check("ready_after_load", fetch_ready, 1);
        fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
        idle(2);

        fetch(32'h6); fetch(32'h4); fetch(32'h100);
        idle(3);
        check("hold_fault", instr_fault, 1);
        check("hold_instr", instruction, 0);

        ldq.delete();
        for (int i = 0; i < 65; i++) ldq.push_back(32'hC0DE0000 + i);
        load_words(1, 65, 0);
        check("ready_after_64", fetch_ready, 1);
        fetch(32'h0); fetch(32'hFC); fetch(32'h80); fetch(32'h100);
        idle(2);

        ldq = '{32'h11111111, 32'hAAAA0000};
        load_words(1, 2, 1);
        idle(1);
        load_start = 1'b1;
        fetch(32'h4);
        load_start = 1'b0;
        fetch_req  = 1'b0;
        ldq = '{32'h12345678, 32'h5555FFFF};
        load_words(0, 2, 1);
        fetch(32'h4); fetch(32'h0);
        idle(2);

        ldq.delete();
        for (int i = 0; i < 10; i++) ldq.push_back(32'hBEEF0000 + i);
        load_words(1, 10, 0);
        fetch_req = 1'b1; fetch_addr = 32'h0;
        step();
        fetch_req = 1'b0;
        rst = 1'b1;
        step();
        chk_reset_outs("rst_midload");
        rst = 1'b0;
        wait_clear("reclear_cycles");
        fetch(32'h0); fetch(32'h4); fetch(32'h24); fetch(32'hFC);
        idle(3);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loadable.md
IMEM_LOADABLE -- requirements
Module: imem_loadable

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 64, number of words; power of two, at least 4.
REQ-003 Parameter ADDR_W, default 32, byte-address width of fetch_addr.
REQ-004 Parameter NOP_WORD, default all-zero DATA_W value; returned on faulted fetches and used as the clear value.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 fetch_req  input  1  fetch request, sampled on a clk edge when fetch_ready=1.
REQ-008 fetch_addr  input  ADDR_W  byte address of the requested word.
REQ-009 fetch_ready  output  1  block accepts a fetch this cycle.
REQ-010 instr_valid  output  1  instruction/instr_fault valid, one-cycle pulse per accepted fetch.
REQ-011 instruction  output  DATA_W  fetched word, registered.
REQ-012 instr_fault  output  1  accepted fetch was misaligned or out of range.
REQ-013 load_start  input  1  begin program load at word 0.
REQ-014 load_valid  input  1  load_data is valid this cycle.
REQ-015 load_data  input  DATA_W  word to write.
REQ-016 load_last  input  1  qualifies load_valid; marks final word of the load.
REQ-017 load_ready  output  1  block accepts load words this cycle.
REQ-018 load_done  output  1  one-cycle pulse when a load completes.

Function
REQ-019 The state machine SHALL have three states: CLEAR, READY, LOAD.
REQ-020 CLEAR SHALL write NOP_WORD to one word per cycle, indices 0..DEPTH-1, then enter READY; duration is exactly DEPTH cycles.
REQ-021 fetch_ready SHALL be 1 only in READY; load_ready SHALL be 1 only in LOAD.
REQ-022 A fetch is accepted on an edge with fetch_ready=1 and fetch_req=1; instr_valid SHALL be 1 on the following cycle only (latency 1).
REQ-023 The word index SHALL be fetch_addr[ADDR_W-1:2].
REQ-024 If fetch_addr[1:0]!=0 or the word index >= DEPTH, the response SHALL be instr_fault=1 with instruction=NOP_WORD; otherwise it SHALL be instr_fault=0 with instruction=memory[index].
REQ-025 Back-to-back fetches SHALL be accepted every cycle in READY (throughput 1 per cycle).
REQ-026 instruction and instr_fault SHALL hold their values while instr_valid=0.
REQ-027 In READY, load_start=1 SHALL move to LOAD with the write pointer set to 0.
REQ-028 If load_start and fetch_req are both 1 in READY, the fetch SHALL still be accepted and SHALL return pre-load contents; the state still moves to LOAD.
REQ-029 In LOAD, each edge with load_valid=1 SHALL write load_data to memory[pointer] and increment the pointer.
REQ-030 LOAD SHALL end after the write with load_last=1, or after the write to index DEPTH-1, whichever comes first; the state then returns to READY.
REQ-031 load_done SHALL pulse the cycle after the final write; words above the last written index SHALL be unchanged.
REQ-032 load_start SHALL be ignored in CLEAR and LOAD; load_valid SHALL be ignored outside LOAD.
REQ-033 Fetch requests outside READY SHALL be ignored, with no later response.

Reset
REQ-034 rst=1 at an edge SHALL force state CLEAR with the clear pointer set to 0, including when asserted mid-LOAD or mid-CLEAR (any partial load is abandoned).
REQ-035 While rst=1 and on the cycle after it, the outputs SHALL be: instr_valid=0, instr_fault=0, instruction=NOP_WORD, load_done=0, fetch_ready=0, load_ready=0.
REQ-036 After rst is released, fetch_ready SHALL rise exactly DEPTH cycles later.

Verification
REQ-037 Reset release, then count cycles -> fetch_ready=1 after exactly 64 cycles; a fetch of address 0x0 returns 0x00000000, fault=0.
REQ-038 Load 3 words 0x20080020, 0x20090037, 0x01098024 (load_last on the 3rd) -> load_done pulses once. Fetches of 0x0, 0x4, 0x8 return those words on consecutive cycles; a fetch of 0xC returns 0.
REQ-039 Fetch 0x6 -> instr_fault=1, instruction=0; fetch 0x100 (index 64) -> instr_fault=1, instruction=0.
REQ-040 Stream 65 load words without load_last -> only 64 are written and load_done pulses after word 64; the 65th word is ignored and fetch_ready=1.
REQ-041 Assert rst after 10 load words -> CLEAR runs, and after 64 cycles all fetches return 0.
REQ-042 load_start together with a fetch of 0x4 (holding 0xAAAA0000) while loading 0x5555FFFF -> the fetch returns 0xAAAA0000; a later fetch of 0x4 returns the newly loaded word.
